ripple_seq_ctrl: RTL and testbench

RIPPLE_SEQ_CTRL -- requirements
Module: ripple_seq_ctrl

---
 rtl/ripple_seq_ctrl.sv | 109 ++++++++++
 tb/tb_ripple_seq_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ripple_seq_ctrl.sv
// Two-requester add engine: one shared 4-bit nibble adder, sequenced LSB nibble
// first, with round-robin arbitration and a valid/ready response handshake.
module ripple_seq_ctrl #(
    parameter  int NIBBLES = 4,
    localparam int W       = 4 * NIBBLES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_sum,
    output logic         rsp_cout,
    output logic         rsp_id,
    output logic         busy
);

    localparam int IW = $clog2(NIBBLES);

    typedef enum logic [1:0] {S_IDLE, S_ADD, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [NIBBLES-1:0][3:0] a_q, b_q, res_q;
    logic [IW-1:0]           idx_q;
    logic                    carry_q;
    logic                    id_q;
    logic                    last_grant_q;

    logic                    idle;
    logic                    grant;
    logic                    accept;
    logic                    last_nib;
    logic [3:0]              nib_sum;
    logic                    nib_cout;

    assign idle = (state_q == S_IDLE);

    // Tie goes to the requester that did not win last; a lone valid always wins.
    always_comb begin
        grant = req1_valid;
        if (req0_valid && req1_valid) grant = ~last_grant_q;
    end

    // rst_n gating keeps both readies low while reset is asserted.
    assign req0_ready = rst_n && idle && req0_valid && !grant;
    assign req1_ready = rst_n && idle && req1_valid && grant;
    assign accept     = req0_ready || req1_ready;

    assign {nib_cout, nib_sum} = {1'b0, a_q[idx_q]} + {1'b0, b_q[idx_q]} + {4'd0, carry_q};
    assign last_nib            = (idx_q == IW'(NIBBLES - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept)    state_d = S_ADD;
            S_ADD:   if (last_nib)  state_d = S_DONE;
            S_DONE:  if (rsp_ready) state_d = S_IDLE;
            default:                state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            a_q          <= '0;
            b_q          <= '0;
            res_q        <= '0;
            idx_q        <= '0;
            carry_q      <= 1'b0;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        a_q          <= grant ? req1_a : req0_a;
                        b_q          <= grant ? req1_b : req0_b;
                        res_q        <= '0;
                        id_q         <= grant;
                        last_grant_q <= grant;
                        carry_q      <= 1'b0;
                        idx_q        <= '0;
                    end
                end
                S_ADD: begin
                    res_q[idx_q] <= nib_sum;
                    carry_q      <= nib_cout;
                    idx_q        <= last_nib ? '0 : idx_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign rsp_valid = (state_q == S_DONE);
    assign busy      = !idle;
    assign rsp_sum   = res_q;
    assign rsp_cout  = carry_q;
    assign rsp_id    = id_q;

endmodule

// File: tb/tb_ripple_seq_ctrl.sv
// Randomized and directed bench for ripple_seq_ctrl against an arithmetic
// reference model (a+b over W+1 bits, round-robin grant from a last-winner bit).
module tb_ripple_seq_ctrl;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         rsp_valid, rsp_ready;
    logic [W-1:0] rsp_sum;
    logic         rsp_cout, rsp_id, busy;

    int   n_tests = 0;
    int   n_fail  = 0;
    logic exp_last;

    ripple_seq_ctrl #(.NIBBLES(NIBBLES)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum),
        .rsp_cout(rsp_cout), .rsp_id(rsp_id), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic model_grant(input logic v0, input logic v1);
        if (v0 && v1) return ~exp_last;
        return v1;
    endfunction

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Present a request for one edge, capturing the readies seen before that edge.
    task automatic send(input logic v0, input logic v1, input logic [W-1:0] a0, b0, a1, b1,
                        output logic r0, output logic r1);
        req0_valid = v0; req1_valid = v1;
        req0_a = a0; req0_b = b0; req1_a = a1; req1_b = b1;
        #1;
        r0 = req0_ready; r1 = req1_ready;
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    // Wait (bounded) for rsp_valid, record it, stall `hold` cycles, then handshake.
    task automatic collect(input int hold, output int lat, output logic [W-1:0] s,
                           output logic c, output logic id);
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 50) begin
            rsp_ready = 1'($urandom_range(0, 1));
            if (!req0_valid && !req1_valid) begin
                req0_a = W'($urandom); req0_b = W'($urandom);
                req1_a = W'($urandom); req1_b = W'($urandom);
            end
            step();
            lat++;
        end
        rsp_ready = 1'b0;
        s = rsp_sum; c = rsp_cout; id = rsp_id;
        repeat (hold) step();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #12;
        rst_n = 1'b1;
        exp_last = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        repeat (2) step();
        n_tests++;
        if ({req0_ready, req1_ready, rsp_valid, busy, rsp_cout, rsp_id} !== 6'b0 || rsp_sum !== '0) begin
            n_fail++;
            $display("FAIL reset_state: rdy=%b%b vld=%b busy=%b sum=%h cout=%b id=%b, want all 0",
                     req0_ready, req1_ready, rsp_valid, busy, rsp_sum, rsp_cout, rsp_id);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        do_reset();
    endtask

    task automatic test_directed();
        logic r0, r1, c, id; logic [W-1:0] s; int lat;
        send(1'b1, 1'b0, 16'hABCD, 16'h1234, 16'h0, 16'h0, r0, r1);
        exp_last = 1'b0;
        collect(0, lat, s, c, id);
        n_tests++;
        if ({r0, r1} !== 2'b10 || lat !== NIBBLES || s !== 16'hBE01 || c !== 1'b0 || id !== 1'b0) begin
            n_fail++;
            $display("FAIL dir_abcd: rdy=%b%b lat=%0d sum=%h cout=%b id=%b, want 10 %0d be01 0 0",
                     r0, r1, lat, s, c, id, NIBBLES);
        end
        send(1'b0, 1'b1, 16'h0, 16'h0, 16'hFFFF, 16'h0001, r0, r1);
        exp_last = 1'b1;
        collect(1, lat, s, c, id);
        n_tests++;
        if ({r0, r1} !== 2'b01 || lat !== NIBBLES || s !== 16'h0000 || c !== 1'b1 || id !== 1'b1) begin
            n_fail++;
            $display("FAIL dir_ripple: rdy=%b%b lat=%0d sum=%h cout=%b id=%b, want 01 %0d 0000 1 1",
                     r0, r1, lat, s, c, id, NIBBLES);
        end
        n_tests++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL dir_release: vld=%b busy=%b, want 0 0", rsp_valid, busy);
        end
    endtask

    task automatic test_tie();
        logic c, id; logic [W-1:0] s; int lat;
        do_reset();
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = 16'h0001; req0_b = 16'h0002; req1_a = 16'h0010; req1_b = 16'h0020;
        #1;
        n_tests++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL tie_first_grant: rdy=%b%b, want 10", req0_ready, req1_ready);
        end
        step();
        req0_valid = 1'b0;
        exp_last = 1'b0;
        n_tests++;
        if (req1_ready !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL tie_blocked: r1=%b busy=%b, want 0 1", req1_ready, busy);
        end
        collect(0, lat, s, c, id);
        n_tests++;
        if (lat !== NIBBLES || s !== 16'h0003 || id !== 1'b0) begin
            n_fail++;
            $display("FAIL tie_req0: lat=%0d sum=%h id=%b, want %0d 0003 0", lat, s, id, NIBBLES);
        end
        n_tests++;
        if (req1_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL tie_req1_pending: r1=%b, want 1", req1_ready);
        end
        step();
        req1_valid = 1'b0;
        exp_last = 1'b1;
        collect(0, lat, s, c, id);
        n_tests++;
        if (lat !== NIBBLES || s !== 16'h0030 || id !== 1'b1) begin
            n_fail++;
            $display("FAIL tie_req1: lat=%0d sum=%h id=%b, want %0d 0030 1", lat, s, id, NIBBLES);
        end
    endtask

    task automatic test_stall();
        logic r0, r1; logic [W-1:0] s0; logic id0; int lat;
        send(1'b0, 1'b1, 16'h0, 16'h0, 16'h7777, 16'h1111, r0, r1);
        exp_last = 1'b1;
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 50) begin step(); lat++; end
        s0 = rsp_sum; id0 = rsp_id;
        n_tests++;
        if (lat !== NIBBLES || s0 !== 16'h8888 || id0 !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_first: lat=%0d sum=%h id=%b, want %0d 8888 1", lat, s0, id0, NIBBLES);
        end
        req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            n_tests++;
            if (rsp_valid !== 1'b1 || rsp_sum !== s0 || rsp_id !== id0 || {req0_ready, req1_ready} !== 2'b00) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: vld=%b sum=%h id=%b rdy=%b%b, want 1 8888 1 00",
                         i, rsp_valid, rsp_sum, rsp_id, req0_ready, req1_ready);
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        n_tests++;
        if (rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_release: vld=%b, want 0", rsp_valid);
        end
    endtask

    task automatic test_reset_mid();
        logic r0, r1, c, id; logic [W-1:0] s; int lat; bit seen;
        send(1'b1, 1'b0, 16'hFFFF, 16'h0001, 16'h0, 16'h0, r0, r1);
        step();
        req0_valid = 1'b1; req1_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({req0_ready, req1_ready, rsp_valid, busy, rsp_cout, rsp_id} !== 6'b0 || rsp_sum !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: rdy=%b%b vld=%b busy=%b sum=%h cout=%b id=%b, want all 0",
                     req0_ready, req1_ready, rsp_valid, busy, rsp_sum, rsp_cout, rsp_id);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        #10;
        rst_n = 1'b1;
        exp_last = 1'b1;
        seen = 0;
        repeat (8) begin step(); if (rsp_valid !== 1'b0 || busy !== 1'b0) seen = 1; end
        n_tests++;
        if (seen) begin
            n_fail++;
            $display("FAIL reset_discard: stale vld/busy after reset, want none");
        end
        send(1'b1, 1'b1, 16'h0100, 16'h0200, 16'h0005, 16'h0006, r0, r1);
        exp_last = 1'b0;
        collect(0, lat, s, c, id);
        n_tests++;
        if ({r0, r1} !== 2'b10 || s !== 16'h0300 || id !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_tie: rdy=%b%b sum=%h id=%b, want 10 0300 0", r0, r1, s, id);
        end
    endtask

    task automatic test_random();
        logic v0, v1, r0, r1, g, c, id; logic [W-1:0] a0, b0, a1, b1, s;
        logic [W:0] full; int lat, hold;
        for (int i = 0; i < 40; i++) begin
            v0 = 1'($urandom_range(0, 1)); v1 = 1'($urandom_range(0, 1));
            if (!v0 && !v1) v0 = 1'b1;
            a0 = W'($urandom); b0 = W'($urandom); a1 = W'($urandom); b1 = W'($urandom);
            if (i < 4) begin a0 = '1; b0 = W'(i); end
            g = model_grant(v0, v1);
            full = g ? ({1'b0, a1} + {1'b0, b1}) : ({1'b0, a0} + {1'b0, b0});
            hold = $urandom_range(0, 3);
            send(v0, v1, a0, b0, a1, b1, r0, r1);
            exp_last = g;
            collect(hold, lat, s, c, id);
            n_tests++;
            if (r0 !== !g || r1 !== g || lat !== NIBBLES || s !== full[W-1:0] || c !== full[W] || id !== g) begin
                n_fail++;
                $display("FAIL rand[%0d]: rdy=%b%b lat=%0d sum=%h cout=%b id=%b, want %b%b %0d %h %b %b",
                         i, r0, r1, lat, s, c, id, !g, g, NIBBLES, full[W-1:0], full[W], g);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_tie();
        test_stall();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
